// File: rtl/read_from_ddr3.sv
// -----------------------------------------------------------------------------
// read_from_ddr3
//
// Avalon-MM read master for the DDR3 controller local interface. The block
// takes one read command (word address plus a burst length), issues a single
// burst read request to the controller and forwards every returned beat to the
// requester as a registered 128-bit word. A one-cycle done pulse accompanies
// the last beat. A watchdog abandons reads whose data stops arriving.
// Everything runs in the ddr3_clk domain.
//
// Parameters
//   MAX_BURST       largest legal burst in beats (1..7)
//   TIMEOUT_CYCLES  beat-less WAIT_DATA cycles tolerated before abandoning the
//                   read (1..1023)
//
// Ports
//   ddr3_clk              sole clock, rising edge
//   ddr3_reset            asynchronous active-high reset
//   rd_req                read command, sampled only while idle
//   rd_addr[25:0]         word address, sampled with rd_req
//   rd_size[2:0]          beats requested (0 treated as 1, clamped to MAX_BURST)
//   rd_busy               command accepted and not yet finished / abandoned
//   rd_data[127:0]        last forwarded beat, held between beats
//   rd_data_valid         one-cycle strobe per forwarded beat
//   rd_done               one-cycle pulse with the last beat
//   rd_timeout            one-cycle pulse when a read is abandoned
//   ddr3_avl_ready        controller ready (low = wait)
//   ddr3_avl_burstbegin   first-cycle marker of the request
//   ddr3_avl_read_req     read request, held until accepted
//   ddr3_avl_addr[25:0]   request address
//   ddr3_avl_size[2:0]    request burst length
//   ddr3_avl_rdata[127:0] read data from the controller
//   ddr3_avl_rdata_valid  read data valid
//   debug_out[3:0]        {state[1:0], beat_cnt[1:0]}
// -----------------------------------------------------------------------------
module read_from_ddr3 #(
  parameter int MAX_BURST      = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         ddr3_clk,
  input  logic         ddr3_reset,
  input  logic         rd_req,
  input  logic [25:0]  rd_addr,
  input  logic [2:0]   rd_size,
  output logic         rd_busy,
  output logic [127:0] rd_data,
  output logic         rd_data_valid,
  output logic         rd_done,
  output logic         rd_timeout,
  input  logic         ddr3_avl_ready,
  output logic         ddr3_avl_burstbegin,
  output logic         ddr3_avl_read_req,
  output logic [25:0]  ddr3_avl_addr,
  output logic [2:0]   ddr3_avl_size,
  input  logic [127:0] ddr3_avl_rdata,
  input  logic         ddr3_avl_rdata_valid,
  output logic [3:0]   debug_out
);

  localparam logic [2:0] MAX_LEN  = 3'(MAX_BURST);
  localparam logic [9:0] TO_LIMIT = 10'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] len;
  logic [2:0] beat_cnt;
  logic [9:0] to_cnt;

  logic [2:0] beat_cnt_next;
  logic [9:0] to_cnt_next;

  // Burst length legalisation: zero means a single beat, oversize requests
  // are trimmed to the largest burst the controller port is set up for.
  function automatic logic [2:0] clamp_size(input logic [2:0] sz);
    logic [2:0] r;
    if (sz == 3'd0) begin
      r = 3'd1;
    end else if (sz > MAX_LEN) begin
      r = MAX_LEN;
    end else begin
      r = sz;
    end
    return r;
  endfunction

  always_comb begin
    beat_cnt_next = beat_cnt + 3'd1;
    to_cnt_next   = to_cnt + 10'd1;
  end

  // Both fields come straight from registers, so the debug port is registered.
  assign debug_out = {state[1:0], beat_cnt[1:0]};

  always_ff @(posedge ddr3_clk or posedge ddr3_reset) begin
    if (ddr3_reset) begin
      state               <= IDLE;
      len                 <= 3'd0;
      beat_cnt            <= 3'd0;
      to_cnt              <= 10'd0;
      rd_busy             <= 1'b0;
      rd_data             <= '0;
      rd_data_valid       <= 1'b0;
      rd_done             <= 1'b0;
      rd_timeout          <= 1'b0;
      ddr3_avl_burstbegin <= 1'b0;
      ddr3_avl_read_req   <= 1'b0;
      ddr3_avl_addr       <= 26'd0;
      ddr3_avl_size       <= 3'd1;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      rd_data_valid <= 1'b0;
      rd_done       <= 1'b0;
      rd_timeout    <= 1'b0;

      case (state)
        IDLE: begin
          // Returning data here belongs to a finished or abandoned read and
          // is dropped on purpose.
          if (rd_req) begin
            len                 <= clamp_size(rd_size);
            ddr3_avl_addr       <= rd_addr;
            ddr3_avl_size       <= clamp_size(rd_size);
            ddr3_avl_read_req   <= 1'b1;
            ddr3_avl_burstbegin <= 1'b1;
            rd_busy             <= 1'b1;
            beat_cnt            <= 3'd0;
            state               <= REQUEST;
          end
        end

        REQUEST: begin
          // burstbegin marks only the first request cycle; read_req, addr and
          // size stay put until the controller takes them. No watchdog here:
          // a stall on ready may last indefinitely.
          ddr3_avl_burstbegin <= 1'b0;
          if (ddr3_avl_ready) begin
            ddr3_avl_read_req <= 1'b0;
            to_cnt            <= 10'd0;
            state             <= WAIT_DATA;
          end
        end

        WAIT_DATA: begin
          if (ddr3_avl_rdata_valid) begin
            rd_data       <= ddr3_avl_rdata;
            rd_data_valid <= 1'b1;
            beat_cnt      <= beat_cnt_next;
            to_cnt        <= 10'd0;
            if (beat_cnt_next == len) begin
              rd_done <= 1'b1;
              rd_busy <= 1'b0;
              state   <= IDLE;
            end
          end else if (to_cnt_next == TO_LIMIT) begin
            // Watchdog expiry: give up on the outstanding read with no done.
            to_cnt     <= to_cnt_next;
            rd_timeout <= 1'b1;
            rd_busy    <= 1'b0;
            state      <= IDLE;
          end else begin
            to_cnt <= to_cnt_next;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
